regfile_wb_sched: RTL and testbench

Write-back scheduler for the 64-bit integer register file. It shares the file's single write port between NUM_REQ producers (ALU, load/store unit, multiply/divide unit) using round-robin arbitration. It drives the per-register write enables of the 32 x 64-bit register array, and keeps a busy scoreboard that issue logic uses to stall on pending destinations.

---
 rtl/regfile_wb_sched_pkg.sv | 28 ++
 rtl/regfile_wb_sched_rr_arbiter.sv | 49 ++++
 rtl/regfile_wb_sched.sv | 100 ++++++++++
 tb/tb_regfile_wb_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler.
package regfile_wb_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REQ   = 3;

  // Requester indices into the arbiter request vector
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  // Register write-enable decode; x0 is never written
  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_IDX_W-1:0] rd);
    logic [NREGS-1:0] v;
    v     = '0;
    v[rd] = (rd != '0);
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: rotating search pointer, one-hot combinational grant.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] w_idx;
  logic [N-1:0]     w_gnt;
  logic             w_found;

  // First valid requester starting at r_ptr, wrapping; next pointer follows the winner
  always_comb begin
    w_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = PTR_W'((32'(r_ptr) + k) % N);
      if (en && !reset && !w_found && req[w_idx]) begin
        w_found      = 1'b1;
        w_gnt[w_idx] = 1'b1;
        w_ptr_nxt    = PTR_W'((32'(w_idx) + 32'd1) % N);
      end
    end
  end

  // Pointer register; a disabled (flush) cycle restarts the search at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (!en) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign gnt = w_gnt;

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates producers onto the single RF write port
// and tracks outstanding destinations in a busy scoreboard.
module regfile_wb_sched #(
  parameter int unsigned NUM_REQ = regfile_wb_pkg::NUM_REQ,
  parameter int unsigned XLEN    = regfile_wb_pkg::XLEN,
  parameter int unsigned NREGS   = regfile_wb_pkg::NREGS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic                    flush,
  output logic [NREGS-1:0]        busy,
  output logic [NREGS-1:0]        rf_wr_en,
  output logic [XLEN-1:0]         rf_wr_data,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd
);

  import regfile_wb_pkg::*;

  wb_req_t                w_sel;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [NREGS-1:0]       w_busy_nxt;
  logic [NREGS-1:0]       r_busy;
  logic [NREGS-1:0]       r_wr_en;
  logic [XLEN-1:0]        r_wr_data;
  logic                   r_wb_valid;
  logic [REG_IDX_W-1:0]   r_wb_rd;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (!flush),
    .gnt   (w_gnt)
  );

  assign req_ready = w_gnt;

  // One-hot mux of the granted requester's payload
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel.valid = 1'b1;
        w_sel.rd    = req_rd[REG_IDX_W*i +: REG_IDX_W];
        w_sel.data  = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // Scoreboard next state: clear on write, set on issue (set wins), flush clears all
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wb_valid) begin
      w_busy_nxt[r_wb_rd] = 1'b0;
    end
    if (issue_valid) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
    if (flush) begin
      w_busy_nxt = '0;
    end
  end

  // Output stage and scoreboard registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_wr_en    <= '0;
      r_wr_data  <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_sel.valid) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= w_sel.rd;
        r_wr_data  <= w_sel.data;
        r_wr_en    <= rd_onehot(w_sel.rd);
      end else begin
        r_wb_valid <= 1'b0;
        r_wr_en    <= '0;
      end
    end
  end

  assign busy       = r_busy;
  assign rf_wr_en   = r_wr_en;
  assign rf_wr_data = r_wr_data;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched.
module tb_regfile_wb_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   req_valid;
  logic [14:0]  req_rd;
  logic [191:0] req_data;
  logic [2:0]   req_ready;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         flush;
  logic [31:0]  busy;
  logic [31:0]  rf_wr_en;
  logic [63:0]  rf_wr_data;
  logic         wb_valid;
  logic [4:0]   wb_rd;

  int total = 0;
  int bad   = 0;

  logic [2:0]  exp_rdy;
  logic [31:0] exp_en;
  logic [63:0] exp_data;

  regfile_wb_sched dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush),
    .busy        (busy),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_data  (rf_wr_data),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    req_valid   = '0;
    issue_valid = 1'b0;
    flush       = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 3'b111; req_rd = {5'd7, 5'd6, 5'd5};
    req_data = '0; issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    #3;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (rf_wr_en !== 32'h0) begin bad++; $display("FAIL reset_wr_en got=%h exp=0", rf_wr_en); end
    total++; if (rf_wr_data !== 64'h0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", rf_wr_data); end
    total++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb got=%b/%0d exp=0/0", wb_valid, wb_rd); end
    tick(); tick();
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_rotation();
    req_valid = 3'b111;
    req_rd    = {5'd7, 5'd6, 5'd5};
    req_data  = {64'hC, 64'hB, 64'hA};
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_rdy = 3'(1 << (k % 3));
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rot_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy); end
      if (k > 0) begin
        exp_en   = 32'(1) << (5 + (k - 1) % 3);
        exp_data = 64'(10 + (k - 1) % 3);
        total++; if (rf_wr_en !== exp_en) begin bad++; $display("FAIL rot_wr_en[%0d] got=%h exp=%h", k, rf_wr_en, exp_en); end
        total++; if (rf_wr_data !== exp_data || wb_valid !== 1'b1) begin bad++; $display("FAIL rot_data[%0d] got=%h/%b exp=%h/1", k, rf_wr_data, wb_valid, exp_data); end
      end
      tick();
    end
    req_valid = '0;
    #1;
    total++; if (rf_wr_en !== (32'(1) << 6) || rf_wr_data !== 64'hB) begin bad++; $display("FAIL rot_last got=%h/%h exp=%h/b", rf_wr_en, rf_wr_data, 32'(1) << 6); end
    tick();
    total++; if (wb_valid !== 1'b0 || rf_wr_en !== 32'h0 || rf_wr_data !== 64'hB) begin bad++; $display("FAIL rot_idle got=%b/%h/%h exp=0/0/b", wb_valid, rf_wr_en, rf_wr_data); end
    do_flush();
  endtask

  task automatic test_x0();
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL x0_issue_busy got=%h exp=0", busy); end
    req_valid = 3'b001; req_rd = '0; req_data = '0; req_data[63:0] = 64'hFFFF;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL x0_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0) begin bad++; $display("FAIL x0_wb got=%b/%0d exp=1/0", wb_valid, wb_rd); end
    total++; if (rf_wr_en !== 32'h0 || rf_wr_data !== 64'hFFFF) begin bad++; $display("FAIL x0_wr got=%h/%h exp=0/ffff", rf_wr_en, rf_wr_data); end
    tick();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL x0_busy got=%h exp=0", busy); end
    do_flush();
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (busy !== (32'(1) << 10)) begin bad++; $display("FAIL sb_set got=%h exp=%h", busy, 32'(1) << 10); end
    req_valid = 3'b010; req_rd = {5'd0, 5'd10, 5'd0}; req_data = '0; req_data[127:64] = 64'h1234;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL sb_ready got=%b exp=010", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (rf_wr_en !== (32'(1) << 10) || rf_wr_data !== 64'h1234) begin bad++; $display("FAIL sb_wr got=%h/%h exp=%h/1234", rf_wr_en, rf_wr_data, 32'(1) << 10); end
    total++; if (busy !== (32'(1) << 10)) begin bad++; $display("FAIL sb_hold got=%h exp=%h", busy, 32'(1) << 10); end
    tick();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL sb_clear got=%h exp=0", busy); end
    // Re-issue rd=10 in the cycle its older write clears
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    issue_valid = 1'b0;
    req_valid = 3'b010;
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_rd = 5'd10;
    #1;
    total++; if (wb_valid !== 1'b1 || rf_wr_en !== (32'(1) << 10)) begin bad++; $display("FAIL sb_clrcyc got=%b/%h exp=1/%h", wb_valid, rf_wr_en, 32'(1) << 10); end
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (busy !== (32'(1) << 10)) begin bad++; $display("FAIL sb_setwins got=%h exp=%h", busy, 32'(1) << 10); end
    do_flush();
  endtask

  task automatic test_flush();
    req_valid = 3'b001; req_rd = {5'd2, 5'd0, 5'd1}; req_data = '0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    req_valid = '0; issue_rd = 5'd4;
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (busy !== 32'h18) begin bad++; $display("FAIL fl_busy_pre got=%h exp=18", busy); end
    req_valid = 3'b100; flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL fl_ready got=%b exp=000", req_ready); end
    tick();
    flush = 1'b0; issue_valid = 1'b0; req_valid = 3'b111;
    #1;
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL fl_busy got=%h exp=0", busy); end
    total++; if (wb_valid !== 1'b0 || rf_wr_en !== 32'h0) begin bad++; $display("FAIL fl_wb got=%b/%h exp=0/0", wb_valid, rf_wr_en); end
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL fl_ptr got=%b exp=001", req_ready); end
    do_flush();
  endtask

  task automatic test_single();
    req_valid = 3'b100; req_rd = {5'd20, 5'd0, 5'd0}; req_data = '0;
    for (int k = 0; k < 4; k++) begin
      req_data[191:128] = 64'h100 + 64'(k);
      #1;
      total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL single_ready[%0d] got=%b exp=100", k, req_ready); end
      if (k > 0) begin
        exp_data = 64'h100 + 64'(k - 1);
        total++; if (rf_wr_en !== (32'(1) << 20) || rf_wr_data !== exp_data || wb_valid !== 1'b1) begin
          bad++; $display("FAIL single_wr[%0d] got=%h/%h/%b exp=%h/%h/1", k, rf_wr_en, rf_wr_data, wb_valid, 32'(1) << 20, exp_data);
        end
      end
      tick();
    end
    req_valid = '0;
    #1;
    total++; if (rf_wr_en !== (32'(1) << 20) || rf_wr_data !== 64'h103) begin bad++; $display("FAIL single_last got=%h/%h exp=%h/103", rf_wr_en, rf_wr_data, 32'(1) << 20); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", wb_valid); end
    do_flush();
  endtask

  task automatic test_async_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    req_valid = 3'b111; req_rd = {5'd7, 5'd6, 5'd5}; req_data = {64'hC, 64'hB, 64'hA};
    tick();
    #1;
    total++; if (wb_valid !== 1'b1 || busy !== (32'(1) << 9)) begin bad++; $display("FAIL ares_pre got=%b/%h exp=1/%h", wb_valid, busy, 32'(1) << 9); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (busy !== 32'h0 || rf_wr_en !== 32'h0) begin bad++; $display("FAIL ares_regs got=%h/%h exp=0/0", busy, rf_wr_en); end
    total++; if (wb_valid !== 1'b0 || rf_wr_data !== 64'h0) begin bad++; $display("FAIL ares_wb got=%b/%h exp=0/0", wb_valid, rf_wr_data); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL ares_ready got=%b exp=000", req_ready); end
    tick();
    req_valid = '0;
    reset = 1'b0;
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL ares_after got=%b exp=0", wb_valid); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_x0();
    test_scoreboard();
    test_flush();
    test_single();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
